// File: rtl/conv3x3_pkg.sv
`timescale 1ns/1ps
// conv3x3_pkg.sv - shared mode encoding, kernel weights and helpers for conv3x3_filter
package conv3x3_pkg;

    typedef enum logic [1:0] {
        MODE_GAUSS    = 2'd0,
        MODE_BYPASS   = 2'd1,
        MODE_SHARPEN  = 2'd2,
        MODE_RESERVED = 2'd3
    } mode_e;

    // Gaussian kernel [1 2 1; 2 4 2; 1 2 1], normalised by >>4
    localparam int GAUSS_W_CORNER = 1;
    localparam int GAUSS_W_EDGE   = 2;
    localparam int GAUSS_W_CENTRE = 4;
    localparam int GAUSS_SHIFT    = 4;
    localparam int GAUSS_ROUND    = 8;

    // Sharpen kernel: 5*c minus the four direct neighbours
    localparam int SHARPEN_W_CENTRE = 5;

    // Accumulator is DATA_W plus this many guard bits
    localparam int ACC_EXTRA_W = 4;

    // Saturate a signed result into the pixel range [0, max_val]
    function automatic int clamp_pixel(input int value, input int max_val);
        if (value < 0) begin
            return 0;
        end
        if (value > max_val) begin
            return max_val;
        end
        return value;
    endfunction

endpackage

// File: rtl/conv3x3_line_buffer.sv
`timescale 1ns/1ps
// conv3x3_line_buffer.sv - single-port line RAM, read-before-write (asynchronous read, registered write)
module conv3x3_line_buffer
    import conv3x3_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Read returns the old contents; the write only lands at the clock edge
    assign rdata = mem[addr];

    // Store the new pixel for this column
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv3x3_filter.sv
`timescale 1ns/1ps
// conv3x3_filter.sv - streaming 3x3 convolution (Gaussian / bypass / sharpen) on a raster pixel stream.
// One output per fully populated window, 2 clk after the pixel that completes it.
// Optional macro CONV3X3_ROUND_EN: Gaussian mode rounds half up instead of truncating.
module conv3x3_filter
    import conv3x3_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_WIDTH = 2048,
    parameter int WIDTH_W   = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sof,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               data_valid,
    input  logic [WIDTH_W-1:0] img_width,
    input  logic [1:0]         mode,
    output logic [DATA_W-1:0]  data_out,
    output logic               data_out_valid
);

    localparam int COL_W   = $clog2(MAX_WIDTH);
    localparam int ACC_W   = DATA_W + ACC_EXTRA_W;
    localparam int PIX_MAX = (1 << DATA_W) - 1;

    logic               load_pend;
    logic [WIDTH_W-1:0] width_q;
    mode_e              mode_q;
    logic [COL_W-1:0]   col_q;
    logic [1:0]         row_q;

    logic               frame_start;
    logic               take_cfg;
    logic [WIDTH_W-1:0] width_cur;
    logic [WIDTH_W-1:0] width_eff;
    mode_e              mode_cur;
    logic [COL_W-1:0]   col_cur;
    logic [1:0]         row_cur;
    logic               line_end;
    logic               win_fire;

    logic [DATA_W-1:0]  lb0_rd;
    logic [DATA_W-1:0]  lb1_rd;
    logic [DATA_W-1:0]  win [0:2][0:2];
    logic               win_vld;
    mode_e              win_mode;

    int                 gauss_sum;
    int                 sharp_sum;
    logic [ACC_W-1:0]   acc_next;
    logic [ACC_W-1:0]   acc_q;
    logic               s1_vld;
    mode_e              s1_mode;
    int                 norm_val;
    logic [DATA_W-1:0]  out_next;

    // Resolve the effective position and configuration for the pixel on the input this cycle
    always_comb begin
        frame_start = sof & data_valid;
        take_cfg    = load_pend | frame_start;
        width_cur   = take_cfg ? img_width : width_q;
        mode_cur    = take_cfg ? mode_e'(mode) : mode_q;
        width_eff   = (int'(width_cur) > MAX_WIDTH) ? WIDTH_W'(MAX_WIDTH) : width_cur;
        col_cur     = frame_start ? '0 : col_q;
        row_cur     = frame_start ? 2'd0 : row_q;
        line_end    = (int'(col_cur) + 1) >= int'(width_eff);
        win_fire    = data_valid && (row_cur == 2'd2) && (col_cur >= COL_W'(2));
    end

    // Shadow configuration and raster counters; row saturates once both line buffers are full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_pend <= 1'b1;
            width_q   <= '0;
            mode_q    <= MODE_GAUSS;
            col_q     <= '0;
            row_q     <= 2'd0;
        end else begin
            load_pend <= 1'b0;
            if (take_cfg) begin
                width_q <= img_width;
                mode_q  <= mode_e'(mode);
            end
            if (data_valid) begin
                if (line_end) begin
                    col_q <= '0;
                    row_q <= (row_cur == 2'd2) ? 2'd2 : row_cur + 2'd1;
                end else begin
                    col_q <= col_cur + COL_W'(1);
                    row_q <= row_cur;
                end
            end
        end
    end

    conv3x3_line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_WIDTH),
        .ADDR_W (COL_W)
    ) u_lb0 (
        .clk   (clk),
        .we    (data_valid),
        .addr  (col_cur),
        .wdata (data_in),
        .rdata (lb0_rd)
    );

    conv3x3_line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_WIDTH),
        .ADDR_W (COL_W)
    ) u_lb1 (
        .clk   (clk),
        .we    (data_valid),
        .addr  (col_cur),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    // Shift a new column (row r-2, r-1, r) into the window on every accepted pixel
    always_ff @(posedge clk) begin
        if (data_valid) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1_rd;
            win[1][2] <= lb0_rd;
            win[2][2] <= data_in;
        end
    end

    // Flag that the window just loaded is complete, carrying the frame's kernel choice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_vld  <= 1'b0;
            win_mode <= MODE_GAUSS;
        end else begin
            win_vld <= win_fire;
            if (win_fire) begin
                win_mode <= mode_cur;
            end
        end
    end

    // Weighted sum for the selected kernel; sharpen is kept as two's complement bits
    always_comb begin
        gauss_sum = GAUSS_W_CORNER * (int'(win[0][0]) + int'(win[0][2]) + int'(win[2][0]) + int'(win[2][2]))
                  + GAUSS_W_EDGE   * (int'(win[0][1]) + int'(win[1][0]) + int'(win[1][2]) + int'(win[2][1]))
                  + GAUSS_W_CENTRE * int'(win[1][1]);
        sharp_sum = SHARPEN_W_CENTRE * int'(win[1][1])
                  - int'(win[0][1]) - int'(win[2][1]) - int'(win[1][0]) - int'(win[1][2]);
        acc_next  = ACC_W'(gauss_sum);
        case (win_mode)
            MODE_BYPASS:  acc_next = ACC_W'(int'(win[1][1]));
            MODE_SHARPEN: acc_next = ACC_W'(sharp_sum);
            default:      acc_next = ACC_W'(gauss_sum);
        endcase
    end

    // Stage 1: register the accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            s1_vld  <= 1'b0;
            s1_mode <= MODE_GAUSS;
        end else begin
            s1_vld <= win_vld;
            if (win_vld) begin
                acc_q   <= acc_next;
                s1_mode <= win_mode;
            end
        end
    end

    // Normalise the accumulator per kernel and clamp it into the pixel range
    always_comb begin
        norm_val = 0;
        case (s1_mode)
            MODE_SHARPEN: norm_val = int'($signed(acc_q));
            MODE_BYPASS:  norm_val = int'(acc_q);
            default: begin
`ifdef CONV3X3_ROUND_EN
                norm_val = (int'(acc_q) + GAUSS_ROUND) >>> GAUSS_SHIFT;
`else
                norm_val = int'(acc_q) >>> GAUSS_SHIFT;
`endif
            end
        endcase
        out_next = DATA_W'(clamp_pixel(norm_val, PIX_MAX));
    end

    // Stage 2: register the output pixel and its one-cycle qualifier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= s1_vld;
            if (s1_vld) begin
                data_out <= out_next;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_filter.sv
`timescale 1ns/1ps
// tb_conv3x3_filter.sv - directed self-checking bench for conv3x3_filter
module tb_conv3x3_filter;

    localparam int DATA_W    = 8;
    localparam int MAX_WIDTH = 2048;
    localparam int WIDTH_W   = 12;

    logic               clk        = 1'b0;
    logic               rst_n      = 1'b0;
    logic               sof        = 1'b0;
    logic               data_valid = 1'b0;
    logic [DATA_W-1:0]  data_in    = '0;
    logic [WIDTH_W-1:0] img_width  = 12'd32;
    logic [1:0]         mode       = 2'd0;
    logic [DATA_W-1:0]  data_out;
    logic               data_out_valid;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int out_val[$];
    int out_cyc[$];
    int pix_edge[$];

    conv3x3_filter #(
        .DATA_W    (DATA_W),
        .MAX_WIDTH (MAX_WIDTH),
        .WIDTH_W   (WIDTH_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sof            (sof),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .img_width      (img_width),
        .mode           (mode),
        .data_out       (data_out),
        .data_out_valid (data_out_valid)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Edge counter: value after edge N is N
    always @(posedge clk) cyc <= cyc + 1;

    // Log every output pixel and the edge count it became visible after
    always @(negedge clk) begin
        if (data_out_valid) begin
            out_val.push_back(int'(data_out));
            out_cyc.push_back(cyc);
        end
    end

    task automatic clear_log();
        out_val.delete();
        out_cyc.delete();
        pix_edge.delete();
    endtask

    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            data_valid = 1'b0;
            sof        = 1'b0;
        end
    endtask

    // kind 0: ramp (i mod 256), 1: constant 100, 2: impulse 255 at (1,1)
    // alt_w/alt_m are applied from the second pixel on, without sof
    task automatic drive_stream(input int w, input int npix, input int kind, input int m,
                                input bit gaps, input bit use_sof, input int alt_w, input int alt_m);
        img_width = WIDTH_W'(w);
        mode      = 2'(m);
        for (int i = 0; i < npix; i++) begin
            @(negedge clk);
            if (i == 1) begin
                img_width = WIDTH_W'(alt_w);
                mode      = 2'(alt_m);
            end
            case (kind)
                0:       data_in = DATA_W'(i % 256);
                1:       data_in = 8'd100;
                default: data_in = (i == w + 1) ? 8'd255 : 8'd0;
            endcase
            data_valid = 1'b1;
            sof        = use_sof && (i == 0);
            pix_edge.push_back(cyc + 1);
            if (gaps) begin
                @(negedge clk);
                data_valid = 1'b0;
                sof        = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        img_width = 12'd32;
        mode      = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (data_out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_valid: got %0b expected 0", data_out_valid);
        end
        checks++;
        if (data_out !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data: got %0d expected 0", data_out);
        end
        rst_n = 1'b1;
        drive_idle(2);
    endtask

    task automatic test_gauss_ramp(input bit gaps);
        int lat;
        clear_log();
        drive_stream(32, 96, 0, 0, gaps, 1'b1, 16, 2);
        drive_idle(8);
        checks++;
        if (out_val.size() != 30) begin
            failures++;
            $display("[TB] FAIL ramp_count(gaps=%0b): got %0d expected 30", gaps, out_val.size());
        end
        for (int i = 0; i < 30; i++) begin
            int got;
            got = (i < out_val.size()) ? out_val[i] : -1;
            checks++;
            if (got != 33 + i) begin
                failures++;
                $display("[TB] FAIL ramp_val(gaps=%0b)[%0d]: got %0d expected %0d", gaps, i, got, 33 + i);
            end
        end
        lat = (out_cyc.size() > 0) ? out_cyc[0] - pix_edge[66] : -1;
        checks++;
        if (lat != 2) begin
            failures++;
            $display("[TB] FAIL ramp_latency(gaps=%0b): got %0d expected 2", gaps, lat);
        end
        if (gaps) begin
            for (int i = 1; i < 30; i++) begin
                int sp;
                sp = (i < out_cyc.size()) ? out_cyc[i] - out_cyc[i-1] : -1;
                checks++;
                if (sp != 2) begin
                    failures++;
                    $display("[TB] FAIL ramp_spacing[%0d]: got %0d expected 2", i, sp);
                end
            end
        end
    endtask

    task automatic test_constant();
        for (int m = 2; m >= 1; m--) begin
            clear_log();
            drive_stream(16, 64, 1, m, 1'b0, 1'b1, 16, m);
            drive_idle(6);
            checks++;
            if (out_val.size() != 28) begin
                failures++;
                $display("[TB] FAIL const_count_m%0d: got %0d expected 28", m, out_val.size());
            end
            for (int i = 0; i < 28; i++) begin
                int got;
                got = (i < out_val.size()) ? out_val[i] : -1;
                checks++;
                if (got != 100) begin
                    failures++;
                    $display("[TB] FAIL const_val_m%0d[%0d]: got %0d expected 100", m, i, got);
                end
            end
        end
    endtask

    task automatic test_impulse();
        int exp_gauss[12];
        int exp_pulse[12];
`ifdef CONV3X3_ROUND_EN
        exp_gauss = '{64, 32, 0, 0, 0, 0, 32, 16, 0, 0, 0, 0};
`else
        exp_gauss = '{63, 31, 0, 0, 0, 0, 31, 15, 0, 0, 0, 0};
`endif
        exp_pulse = '{255, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int m = 0; m < 3; m++) begin
            clear_log();
            // sharpen frame flips the mode input to Gaussian mid-frame; it must be ignored
            drive_stream(8, 32, 2, m, 1'b0, 1'b1, 8, (m == 2) ? 0 : m);
            drive_idle(6);
            checks++;
            if (out_val.size() != 12) begin
                failures++;
                $display("[TB] FAIL impulse_count_m%0d: got %0d expected 12", m, out_val.size());
            end
            for (int i = 0; i < 12; i++) begin
                int got;
                int exp;
                got = (i < out_val.size()) ? out_val[i] : -1;
                exp = (m == 0) ? exp_gauss[i] : exp_pulse[i];
                checks++;
                if (got != exp) begin
                    failures++;
                    $display("[TB] FAIL impulse_m%0d[%0d]: got %0d expected %0d", m, i, got, exp);
                end
            end
        end
    endtask

    task automatic test_midframe_sof();
        int lat;
        clear_log();
        drive_stream(32, 80, 0, 0, 1'b0, 1'b1, 32, 0);
        drive_idle(6);
        checks++;
        if (out_val.size() != 14) begin
            failures++;
            $display("[TB] FAIL partial_count: got %0d expected 14", out_val.size());
        end
        clear_log();
        drive_stream(16, 48, 0, 0, 1'b0, 1'b1, 16, 0);
        drive_idle(6);
        checks++;
        if (out_val.size() != 14) begin
            failures++;
            $display("[TB] FAIL sof_count: got %0d expected 14", out_val.size());
        end
        for (int i = 0; i < 14; i++) begin
            int got;
            got = (i < out_val.size()) ? out_val[i] : -1;
            checks++;
            if (got != 17 + i) begin
                failures++;
                $display("[TB] FAIL sof_val[%0d]: got %0d expected %0d", i, got, 17 + i);
            end
        end
        lat = (out_cyc.size() > 0) ? out_cyc[0] - pix_edge[34] : -1;
        checks++;
        if (lat != 2) begin
            failures++;
            $display("[TB] FAIL sof_latency: got %0d expected 2", lat);
        end
    endtask

    task automatic test_reset_midframe();
        int n0;
        int lat;
        clear_log();
        drive_stream(32, 70, 0, 0, 1'b0, 1'b1, 32, 0);
        @(posedge clk);
        #2;
        checks++;
        if (data_out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL prereset_valid: got %0b expected 1", data_out_valid);
        end
        rst_n      = 1'b0;
        data_valid = 1'b0;
        sof        = 1'b0;
        #1;
        checks++;
        if (data_out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset_valid: got %0b expected 0", data_out_valid);
        end
        checks++;
        if (data_out !== '0) begin
            failures++;
            $display("[TB] FAIL async_reset_data: got %0d expected 0", data_out);
        end
        n0 = out_val.size();
        repeat (3) @(negedge clk);
        checks++;
        if (out_val.size() != n0) begin
            failures++;
            $display("[TB] FAIL reset_hold_outputs: got %0d expected %0d", out_val.size(), n0);
        end
        rst_n = 1'b1;
        clear_log();
        drive_stream(32, 96, 0, 0, 1'b0, 1'b0, 32, 0);
        drive_idle(6);
        checks++;
        if (out_val.size() != 30) begin
            failures++;
            $display("[TB] FAIL postreset_count: got %0d expected 30", out_val.size());
        end
        for (int i = 0; i < 30; i++) begin
            int got;
            got = (i < out_val.size()) ? out_val[i] : -1;
            checks++;
            if (got != 33 + i) begin
                failures++;
                $display("[TB] FAIL postreset_val[%0d]: got %0d expected %0d", i, got, 33 + i);
            end
        end
        lat = (out_cyc.size() > 0) ? out_cyc[0] - pix_edge[66] : -1;
        checks++;
        if (lat != 2) begin
            failures++;
            $display("[TB] FAIL postreset_latency: got %0d expected 2", lat);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        $display("[TB] starting conv3x3_filter bench");
        test_reset();
        test_gauss_ramp(1'b0);
        test_constant();
        test_impulse();
        test_midframe_sof();
        test_reset_midframe();
        test_gauss_ramp(1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
